// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding, forwarding-mux select codes and the default register-address width.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    BR_FLUSH = 2'd2,
    IF_WAIT  = 2'd3
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

  localparam int REG_AW_DEF = 5;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage forwarding compare for both ALU operands; purely combinational.
// A newer EX/MEM result wins over an older MEM/WB result, and register 0 never forwards.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex_reg_write && (ex_rd != '0) && (ex_rd == src))
      sel = FWD_EX;
    else if (mem_reg_write && (mem_rd != '0) && (mem_rd == src))
      sel = FWD_MEM;
    return sel;
  endfunction

  assign fwd_a = fwd_sel(id_rs);
  assign fwd_b = fwd_sel(id_rt);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use stalls, taken-beq flushes, fetch waits, forwarding.
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYC = 1,
  parameter int REG_AW         = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic              beq_taken,
  input  logic              imem_ready,
  output logic              pc_write,
  output logic              pc_sel,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        state_o,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       flush_events
);

  localparam logic [2:0] LOAD_CNT = 3'(LOAD_STALL_CYC - 1);

  state_t     state;
  logic [2:0] stall_cnt;
  logic       lu;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  fwd_unit #(.REG_AW(REG_AW)) u_fwd (
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .fwd_a         (fwd_a_raw),
    .fwd_b         (fwd_b_raw)
  );

  // While reset is held the muxes show default control even if hazard inputs are live.
  assign fwd_a   = rst ? FWD_RF : fwd_a_raw;
  assign fwd_b   = rst ? FWD_RF : fwd_b_raw;
  assign state_o = state;

  always_comb begin
    pc_write     = 1'b1;
    pc_sel       = 1'b0;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (!rst) begin
      if (beq_taken) begin
        pc_sel       = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if ((state == LU_STALL) || (lu && (state != BR_FLUSH))) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end else if (!imem_ready) begin
        pc_write    = 1'b0;
        if_id_flush = 1'b1;
      end
    end
  end

  // LU_STALL exits once the remaining count runs out, so a hazard costs LOAD_STALL_CYC bubbles in total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else if (beq_taken) begin
      state     <= BR_FLUSH;
      stall_cnt <= '0;
    end else begin
      case (state)
        LU_STALL: begin
          if (stall_cnt <= 3'd1) begin
            state     <= RUN;
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt - 3'd1;
          end
        end
        BR_FLUSH: state <= imem_ready ? RUN : IF_WAIT;
        default: begin
          if (lu) begin
            stall_cnt <= LOAD_CNT;
            state     <= (LOAD_STALL_CYC == 1) ? RUN : LU_STALL;
          end else begin
            state <= imem_ready ? RUN : IF_WAIT;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && (stall_q != 16'hFFFF))
        stall_q <= stall_q + 16'd1;
      if (beq_taken && (flush_q != 16'hFFFF))
        flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule
